// File: rtl/pooling_result_buffer.sv
// pooling_result_buffer: ping-pong buffer that collects pooled rows into
// per-feature maps and streams each complete map out row by row.
// Latency: 1 cycle from the last input row of a map to output_valid when that bank is next to drain.
// Backpressure: input_ready drops while the write bank is full; a row offered then is dropped and overflow latches.
// Ports: write side  input_valid/input_ready, feature_idx, feature_row, data_in
//        read side   output_valid/output_ready, out_feature_idx, out_row, out_last, data_out
//        status      overflow (sticky until reset)
module pooling_result_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OUTPUT_SIZE   = 3,
  parameter int FEATURE_WIDTH = 3,
  parameter int ROW_WIDTH     = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              input_valid,
  output logic                              input_ready,
  input  logic [FEATURE_WIDTH-1:0]          feature_idx,
  input  logic [ROW_WIDTH-1:0]              feature_row,
  input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_in,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic [FEATURE_WIDTH-1:0]          out_feature_idx,
  output logic [ROW_WIDTH-1:0]              out_row,
  output logic                              out_last,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                              overflow
);

  localparam int RW = OUTPUT_SIZE * DATA_WIDTH;
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(OUTPUT_SIZE - 1);

  // Two banks of OUTPUT_SIZE rows each, with a full flag and latched feature index per bank.
  logic [RW-1:0]            mem_q [2][OUTPUT_SIZE];
  logic [FEATURE_WIDTH-1:0] idx_q [2];
  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [ROW_WIDTH-1:0]     rd_row_q, rd_row_d;
  logic                     overflow_q, overflow_d;

  logic row_ok, wr_fire, wr_last, rd_fire, rd_last;

  assign input_ready = ~full_q[wr_bank_q];
  // Out-of-range rows are silently discarded; they do not touch any state.
  assign row_ok      = (feature_row <= LAST_ROW);
  assign wr_fire     = input_valid & input_ready & row_ok;
  assign wr_last     = wr_fire & (feature_row == LAST_ROW);

  assign output_valid    = full_q[rd_bank_q];
  assign out_row         = rd_row_q;
  assign out_last        = (rd_row_q == LAST_ROW);
  assign out_feature_idx = idx_q[rd_bank_q];
  assign overflow        = overflow_q;
  assign rd_fire         = output_valid & output_ready;
  assign rd_last         = rd_fire & out_last;

  // Row select by comparison keeps the row index width independent of OUTPUT_SIZE.
  always_comb begin
    data_out = '0;
    for (int r = 0; r < OUTPUT_SIZE; r++) begin
      if (rd_row_q == ROW_WIDTH'(r)) data_out = mem_q[rd_bank_q][r];
    end
  end

  // A fill of one bank and a drain of the other can complete on the same edge.
  // The write bank can never equal a bank being drained (one is empty, one full),
  // so the two updates never collide. A freed bank is only seen next cycle.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    wr_bank_d  = wr_bank_q ^ wr_last;
    rd_bank_d  = rd_bank_q ^ rd_last;
    rd_row_d   = rd_row_q;
    if (rd_fire) rd_row_d = out_last ? '0 : rd_row_q + 1'b1;
    overflow_d = overflow_q | (input_valid & ~input_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_row_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_row_q   <= rd_row_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        idx_q[b] <= '0;
        for (int r = 0; r < OUTPUT_SIZE; r++) mem_q[b][r] <= '0;
      end
    end else if (wr_fire) begin
      // Row 0 names the map; later rows inherit it regardless of their feature_idx.
      if (feature_row == '0) idx_q[wr_bank_q] <= feature_idx;
      for (int r = 0; r < OUTPUT_SIZE; r++) begin
        if (feature_row == ROW_WIDTH'(r)) mem_q[wr_bank_q][r] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pooling_result_buffer.sv
module tb_pooling_result_buffer;

  localparam int DW = 32;
  localparam int OS = 3;
  localparam int FW = 3;
  localparam int RWD = 3;
  localparam int RW = OS * DW;

  logic          clk, rst_n;
  logic          input_valid, input_ready, output_valid, output_ready, out_last, overflow;
  logic [FW-1:0] feature_idx, out_feature_idx;
  logic [RWD-1:0] feature_row, out_row;
  logic [RW-1:0] data_in, data_out;

  pooling_result_buffer #(.DATA_WIDTH(DW), .OUTPUT_SIZE(OS), .FEATURE_WIDTH(FW), .ROW_WIDTH(RWD)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_valid(input_valid), .input_ready(input_ready),
    .feature_idx(feature_idx), .feature_row(feature_row), .data_in(data_in),
    .output_valid(output_valid), .output_ready(output_ready),
    .out_feature_idx(out_feature_idx), .out_row(out_row), .out_last(out_last),
    .data_out(data_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0]  feat;
    logic [RWD-1:0] row;
    logic           last;
    logic [RW-1:0]  data;
  } beat_t;

  // Reference model: a queue of beats still owed downstream, a count of maps
  // completed vs. drained (at most two may be held), the map being assembled,
  // and the sticky overflow flag.
  beat_t         exp_q[$];
  int            tests = 0, fails = 0;
  int            done_maps = 0, drained_maps = 0;
  bit            ovf_model = 1'b0;
  logic [RW-1:0] part [OS];
  logic [FW-1:0] part_feat;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (done_maps - drained_maps) < 2;
  endfunction

  // One clock of stimulus. Called just after a rising edge; returns just after the next.
  task automatic cycle(input bit v, input logic [RWD-1:0] frow, input logic [FW-1:0] feat,
                       input logic [RW-1:0] d, input bit ordy);
    bit push;
    bit rdy;
    push = 1'b0;
    input_valid  = v;
    feature_row  = frow;
    feature_idx  = feat;
    data_in      = d;
    output_ready = ordy;
    rdy = model_ready();
    chk("input_ready", RW'(input_ready), RW'(rdy));
    if (v && !rdy) ovf_model = 1'b1;
    else if (v && int'(frow) < OS) begin
      part[frow] = d;
      if (frow == 0) part_feat = feat;
      if (int'(frow) == OS - 1) push = 1'b1;
    end
    @(posedge clk);
    #1;
    if (push) begin
      for (int r = 0; r < OS; r++)
        exp_q.push_back('{feat: part_feat, row: RWD'(r), last: (r == OS - 1), data: part[r]});
      done_maps++;
    end
    chk("overflow", RW'(overflow), RW'(ovf_model));
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, ordy);
  endtask

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] d;
    for (int j = 0; j < OS; j++) d[j*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic send_map(input logic [FW-1:0] feat, input bit ordy);
    for (int r = 0; r < OS; r++) cycle(1'b1, RWD'(r), feat, rnd_row(), ordy);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_output_valid", RW'(output_valid), '0);
    chk("rst_input_ready", RW'(input_ready), RW'(1));
    chk("rst_overflow", RW'(overflow), '0);
    chk("rst_out_last", RW'(out_last), '0);
    chk("rst_out_row", RW'(out_row), '0);
    chk("rst_out_feature_idx", RW'(out_feature_idx), '0);
    chk("rst_data_out", data_out, '0);
  endtask

  // Monitor: output_valid must be high exactly when beats are owed; each accepted
  // beat is compared against the head of the queue; stalled outputs must hold.
  bit            stalled = 1'b0;
  beat_t         prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      chk("output_valid", RW'(output_valid), RW'(exp_q.size() != 0));
      if (stalled && output_valid) begin
        chk("stall_data", data_out, prev.data);
        chk("stall_row", RW'(out_row), RW'(prev.row));
        chk("stall_feat", RW'(out_feature_idx), RW'(prev.feat));
      end
      if (output_valid && exp_q.size() != 0) begin
        chk("out_data", data_out, exp_q[0].data);
        chk("out_row", RW'(out_row), RW'(exp_q[0].row));
        chk("out_feature_idx", RW'(out_feature_idx), RW'(exp_q[0].feat));
        chk("out_last", RW'(out_last), RW'(exp_q[0].last));
        if (output_ready) begin
          if (exp_q[0].last) drained_maps++;
          void'(exp_q.pop_front());
        end
      end
      stalled = output_valid && !output_ready;
      prev = '{feat: out_feature_idx, row: out_row, last: out_last, data: data_out};
    end
  end

  initial begin
    logic [RW-1:0] d;
    int nr;
    logic [FW-1:0] cf;
    rst_n = 1'b0; input_valid = 1'b0; feature_row = '0; feature_idx = '0;
    data_in = '0; output_ready = 1'b0;
    #2;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single map, feature 4, float-like values; output follows the last row by one cycle.
    for (int r = 0; r < OS; r++) begin
      for (int j = 0; j < OS; j++) d[(OS-1-j)*DW +: DW] = 32'h3F80_0000 + 32'(r * 16 + j);
      cycle(1'b1, RWD'(r), 3'd4, d, 1'b1);
    end
    idle(4, 1'b1);

    // Back-to-back maps, no gaps.
    for (int f = 0; f < 3; f++) send_map(FW'(f), 1'b1);
    idle(6, 1'b1);

    // Stall mid-drain at out_row 1 for 5 cycles.
    send_map(3'd5, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // Out-of-range row index is ignored.
    cycle(1'b1, 3'd5, 3'd1, rnd_row(), 1'b1);
    cycle(1'b1, 3'd7, 3'd2, rnd_row(), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with random backpressure; non-zero rows carry junk feature indices.
    nr = 0; cf = '0;
    for (int i = 0; i < 3000 && (i < 1500 || nr != 0); i++) begin
      int r;
      bit ordy;
      r = int'($urandom % 10);
      ordy = ($urandom % 4) != 0;
      if (r < 6 && model_ready()) begin
        cycle(1'b1, RWD'(nr), (nr == 0) ? cf : FW'($urandom), rnd_row(), ordy);
        nr++;
        if (nr == OS) begin nr = 0; cf++; end
      end else if (r == 6 && model_ready()) begin
        cycle(1'b1, RWD'(OS + int'($urandom % (8 - OS))), FW'($urandom), rnd_row(), ordy);
      end else begin
        cycle(1'b0, RWD'($urandom), FW'($urandom), rnd_row(), ordy);
      end
    end
    idle(10, 1'b1);
    chk("queue_drained", RW'(exp_q.size()), '0);

    // Backpressure: two maps fill both banks, a third map's first row overflows.
    send_map(3'd0, 1'b0);
    send_map(3'd1, 1'b0);
    cycle(1'b1, 3'd0, 3'd2, rnd_row(), 1'b0);
    idle(3, 1'b0);
    idle(10, 1'b1);
    chk("bp_queue_drained", RW'(exp_q.size()), '0);

    // Reset with one full bank and a partial map in the other.
    send_map(3'd3, 1'b0);
    cycle(1'b1, 3'd0, 3'd6, rnd_row(), 1'b0);
    cycle(1'b1, 3'd1, 3'd6, rnd_row(), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    done_maps = drained_maps;
    ovf_model = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3, 1'b1);
    send_map(3'd2, 1'b1);
    idle(6, 1'b1);
    chk("rst_queue_drained", RW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
